// File: rtl/display_resultado.sv
// Six-digit multiplexed 7-segment display of a 7-bit quotient and remainder.
// Both operands go through a shift-add-3 BCD conversion before display.
module display_resultado #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       done,
    input  logic [6:0] Q,
    input  logic [6:0] R,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       busy,
    output logic       valid
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHOW
    } state_t;

    state_t        state;
    logic [2:0]    iter;
    logic [18:0]   sh_q;
    logic [18:0]   sh_r;
    logic [11:0]   bcd_q;
    logic [11:0]   bcd_r;
    logic [CW-1:0] ref_cnt;
    logic [2:0]    digit;

    logic [18:0] nq;
    logic [18:0] nr;
    logic [11:0] opnd;
    logic [1:0]  pos;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  seg_n;
    logic [5:0]  an_n;

    // Layout: [18:15] hundreds, [14:11] tens, [10:7] ones, [6:0] binary
    function automatic logic [18:0] dd_step(input logic [18:0] s);
        logic [18:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[7+4*i +: 4] >= 4'd5)
                t[7+4*i +: 4] = t[7+4*i +: 4] + 4'd3;
        end
        return {t[17:0], 1'b0};
    endfunction

    assign nq = dd_step(sh_q);
    assign nr = dd_step(sh_r);

    always_comb begin
        opnd = bcd_r;
        pos  = 2'd0;
        unique case (digit)
            3'd0: begin opnd = bcd_r; pos = 2'd0; end
            3'd1: begin opnd = bcd_r; pos = 2'd1; end
            3'd2: begin opnd = bcd_r; pos = 2'd2; end
            3'd3: begin opnd = bcd_q; pos = 2'd0; end
            3'd4: begin opnd = bcd_q; pos = 2'd1; end
            3'd5: begin opnd = bcd_q; pos = 2'd2; end
            default: begin opnd = bcd_r; pos = 2'd0; end
        endcase
        nib   = opnd[{pos, 2'b00} +: 4];
        blank = 1'b0;
        if (pos == 2'd2)
            blank = (opnd[11:8] == 4'd0);
        else if (pos == 2'd1)
            blank = (opnd[11:4] == 8'd0);
        unique case (nib)
            4'd0: seg_n = 7'b1000000;
            4'd1: seg_n = 7'b1111001;
            4'd2: seg_n = 7'b0100100;
            4'd3: seg_n = 7'b0110000;
            4'd4: seg_n = 7'b0011001;
            4'd5: seg_n = 7'b0010010;
            4'd6: seg_n = 7'b0000010;
            4'd7: seg_n = 7'b1111000;
            4'd8: seg_n = 7'b0000000;
            4'd9: seg_n = 7'b0010000;
            default: seg_n = 7'h7F;
        endcase
        if (blank)
            seg_n = 7'h7F;
        an_n = ~(6'b1 << digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iter    <= 3'd0;
            sh_q    <= '0;
            sh_r    <= '0;
            bcd_q   <= '0;
            bcd_r   <= '0;
            ref_cnt <= '0;
            digit   <= 3'd0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            seg     <= 7'h7F;
            an      <= 6'h3F;
        end else begin
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                digit   <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            seg <= valid ? seg_n : 7'h7F;
            an  <= valid ? an_n : 6'h3F;

            unique case (state)
                IDLE, SHOW: begin
                    if (done) begin
                        sh_q  <= {12'd0, Q};
                        sh_r  <= {12'd0, R};
                        iter  <= 3'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sh_q <= nq;
                    sh_r <= nr;
                    iter <= iter + 3'd1;
                    // Display registers keep the old result until the last step
                    if (iter == 3'd6) begin
                        bcd_q <= nq[18:7];
                        bcd_r <= nr[18:7];
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_resultado.sv
// Directed bench for display_resultado with a result scoreboard.
// Expected digit patterns come from a decimal model of Q and R.
module tb_display_resultado;

    logic       clk;
    logic       rst_n;
    logic       done;
    logic [6:0] Q;
    logic [6:0] R;
    logic [6:0] seg;
    logic [5:0] an;
    logic       busy;
    logic       valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int q;
        int r;
    } exp_t;

    exp_t sb[$];
    int   cur_q = 0;
    int   cur_r = 0;

    display_resultado #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .done (done),
        .Q    (Q),
        .R    (R),
        .seg  (seg),
        .an   (an),
        .busy (busy),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int q, input int r, input int k);
        int v, h, t, o;
        v = (k < 3) ? r : q;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (k % 3)
            0: return enc(o);
            1: return (h == 0 && t == 0) ? 7'h7F : enc(t);
            default: return (h == 0) ? 7'h7F : enc(h);
        endcase
    endfunction

    function automatic int active_digit(input logic [5:0] a);
        int k;
        k = -1;
        for (int j = 0; j < 6; j++)
            if (a == ~(6'b1 << j)) k = j;
        return k;
    endfunction

    task automatic scan(input int q, input int r);
        logic [5:0] seen;
        logic [5:0] prev;
        int dwell;
        bit first;
        int k;
        seen  = '0;
        prev  = 6'h3F;
        dwell = 0;
        first = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k = active_digit(an);
            if (k < 0) begin
                chk("an_onehot", 32'(an), 32'h3F);
            end else begin
                seen[k] = 1'b1;
                chk("seg_digit", 32'(seg), 32'(exp_seg(q, r, k)));
                if (an != prev) begin
                    if (prev != 6'h3F) begin
                        chk("an_order", 32'(an), 32'({prev[4:0], prev[5]}));
                        if (!first) chk("dwell", 32'(dwell), 32'd4);
                        first = 1'b0;
                    end
                    dwell = 1;
                    prev  = an;
                end else begin
                    dwell++;
                end
            end
        end
        chk("all_digits", 32'(seen), 32'h3F);
    endtask

    task automatic wait_conv(input int inj, input bit hold);
        int cnt;
        int k;
        exp_t e;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (hold) begin
                chk("valid_hold", 32'(valid), 32'd1);
                k = active_digit(an);
                if (k >= 0)
                    chk("old_digit", 32'(seg), 32'(exp_seg(cur_q, cur_r, k)));
            end
            if (cnt == inj) begin
                Q    = 7'd5;
                R    = 7'd5;
                done = 1'b1;
            end
            @(negedge clk);
            done = 1'b0;
        end
        chk("busy_cycles", 32'(cnt), 32'd7);
        chk("valid_after", 32'(valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            scan(e.q, e.r);
            cur_q = e.q;
            cur_r = e.r;
        end
    endtask

    task automatic run_conv(input int q, input int r, input int inj);
        bit hold;
        hold = valid;
        @(negedge clk);
        Q    = 7'(q);
        R    = 7'(r);
        done = 1'b1;
        sb.push_back('{q, r});
        @(negedge clk);
        done = 1'b0;
        wait_conv(inj, hold);
    endtask

    initial begin
        rst_n = 1'b0;
        done  = 1'b0;
        Q     = '0;
        R     = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h3F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({an, seg, valid, busy}), 32'({6'h3F, 7'h7F, 2'b00}));
        end

        run_conv(41, 0, 0);
        run_conv(0, 5, 0);
        run_conv(18, 1, 0);
        run_conv(127, 126, 3);
        chk("no_restart", 32'(busy), 32'd0);

        // Reset in the middle of a conversion
        @(negedge clk);
        Q    = 7'd99;
        R    = 7'd99;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'h3F);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_after_rst", 32'({busy, valid, an}), 32'({2'b00, 6'h3F}));
        end

        // done coincident with the first edge after reset release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        Q     = 7'd25;
        R     = 7'd2;
        done  = 1'b1;
        sb.push_back('{25, 2});
        @(negedge clk);
        done = 1'b0;
        wait_conv(0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
